// File: rtl/vga_sync_decoder.sv
// Rebuilds 640x480 pixel coordinates, valid window and lock status from a sampled hsync/vsync pair.
// Optional pulse-width checking is enabled by defining VGA_DECODE_WIDTH_CHECK_EN.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  localparam logic [9:0]  H_FALL    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_FALL    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_TIMEOUT = 11'(H_TOTAL + 8);
  localparam logic [10:0] V_TIMEOUT = 11'(V_TOTAL + 2);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

  state_t      state_reg;
  logic        hsync_q, vsync_q;
  logic [10:0] h_gap_reg, v_gap_reg;
  logic [3:0]  good_reg;
  logic        v_aligned_reg;

  logic        fall_h, fall_v, h_wrap, tracking;
  logic [9:0]  h_next, v_next;
  logic        h_bad, h_lost, v_lost, v_check, v_bad, width_bad;
  logic        drop, err_now, lock_step, lock_next;

  always_comb begin
    fall_h = hsync_q & ~hsync;
    fall_v = vsync_q & ~vsync;
    h_wrap = ~fall_h & (h_cnt == H_LAST);

    if (fall_h)      h_next = H_FALL;
    else if (h_wrap) h_next = '0;
    else             h_next = h_cnt + 10'd1;

    // A vsync edge realigns the line count even when it lands on a line wrap.
    v_next = v_cnt;
    if (fall_v)      v_next = V_FALL;
    else if (h_wrap) v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;

    tracking  = (state_reg != SEARCH);
    h_bad     = tracking & fall_h & (h_cnt != H_FALL - 10'd1);
    h_lost    = tracking & ~fall_h & (h_gap_reg > H_TIMEOUT);
    v_lost    = (state_reg == LOCKED) & ~fall_v & h_wrap & (v_gap_reg >= V_TIMEOUT);
    v_check   = tracking & fall_v & v_aligned_reg;
    v_bad     = v_check & (v_cnt != V_FALL - 10'd1);
    drop      = h_bad | h_lost | v_lost | width_bad | ((state_reg == LOCKED) & v_bad);
    err_now   = drop | v_bad;
    lock_step = (state_reg == HLOCK) & v_check & ~v_bad & ((good_reg + 4'd1) == LOCK_N);
    lock_next = ~drop & ((state_reg == LOCKED) | lock_step);
  end

`ifdef VGA_DECODE_WIDTH_CHECK_EN
  logic [10:0] hw_reg;
  logic [9:0]  vw_reg;

  // Pulse lengths: hsync in samples, vsync in lines spent low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hw_reg <= '0;
      vw_reg <= '0;
    end else begin
      if (fall_h)                      hw_reg <= 11'd1;
      else if (~hsync && hw_reg != '1) hw_reg <= hw_reg + 11'd1;
      if (fall_v)                                vw_reg <= 10'd1;
      else if (~vsync && h_wrap && vw_reg != '1) vw_reg <= vw_reg + 10'd1;
    end
  end

  assign width_bad = tracking &
                     ((~hsync_q & hsync & (hw_reg != 11'(H_SYNC))) |
                      (v_aligned_reg & ~vsync_q & vsync & (vw_reg != 10'(V_SYNC))));
`else
  assign width_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SEARCH;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      h_gap_reg     <= '0;
      v_gap_reg     <= '0;
      good_reg      <= '0;
      v_aligned_reg <= 1'b0;
      valid         <= 1'b0;
      locked        <= 1'b0;
      frame_start   <= 1'b0;
      sync_err      <= 1'b0;
      err_cnt       <= '0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      h_cnt   <= h_next;
      v_cnt   <= v_next;

      if (fall_h)                h_gap_reg <= 11'd1;
      else if (h_gap_reg != '1)  h_gap_reg <= h_gap_reg + 11'd1;
      if (fall_v)                          v_gap_reg <= '0;
      else if (h_wrap && v_gap_reg != '1)  v_gap_reg <= v_gap_reg + 11'd1;

      sync_err <= err_now;
      if (err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      locked      <= lock_next;
      valid       <= lock_next & (h_next < 10'(H_ACTIVE)) & (v_next < 10'(V_ACTIVE));
      frame_start <= lock_next & (h_next == '0) & (v_next == '0);

      case (state_reg)
        SEARCH: begin
          if (fall_h) begin
            state_reg     <= HLOCK;
            good_reg      <= '0;
            v_aligned_reg <= 1'b0;
          end
        end
        HLOCK: begin
          if (drop) begin
            state_reg <= SEARCH;
          end else if (fall_v) begin
            v_aligned_reg <= 1'b1;
            if (v_bad) begin
              good_reg <= '0;
            end else if (v_check) begin
              good_reg <= good_reg + 4'd1;
              if (lock_step) state_reg <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (drop) state_reg <= SEARCH;
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (40x20 total, 16x12 visible).
module tb_vga_sync_decoder;

  localparam int HA = 16, HFP = 4, HS = 8, HT = 40;
  localparam int VA = 12, VFP = 2, VS = 2, VT = 20;
  localparam int HF = HA + HFP;
  localparam int VF = VA + VFP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] h_cnt, v_cnt;
  logic       valid, locked, frame_start, sync_err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int gx = 0, gy = 0, frame_no = 0;
  int f_frame = -1, f_line = -1, f_fall = HF, f_rise = HF + HS;
  bit stuck_hi = 1'b0;
  bit prev_locked = 1'b0;
  int rise_code = -1;
  int valid_cnt = 0, fs_cnt = 0, coord_bad = 0, err_seen = 0;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s = %0d", tag, act);
    end
  endtask

  // One sample: drive, let the DUT register it, look 1 time unit after the edge.
  task automatic drive(input logic hs, input logic vs);
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    int   fall_x, rise_x;
    logic hs, vs;
    fall_x = HF;
    rise_x = HF + HS;
    if (frame_no == f_frame && gy == f_line) begin
      fall_x = f_fall;
      rise_x = f_rise;
    end
    hs = stuck_hi || !(gx >= fall_x && gx < rise_x);
    vs = !(gy >= VF && gy < VF + VS);
    drive(hs, vs);
    if (locked && !prev_locked) rise_code = frame_no * 10000 + gy * 100 + gx;
    prev_locked = locked;
    if (locked && (h_cnt != 10'(gx) || v_cnt != 10'(gy))) coord_bad++;
    if (valid !== (locked && gx < HA && gy < VA)) coord_bad++;
    if (valid) valid_cnt++;
    if (frame_start) begin
      fs_cnt++;
      if (!(gx == 0 && gy == 0)) coord_bad++;
    end
    if (sync_err) err_seen++;
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy == VT) begin
        gy = 0;
        frame_no++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) drive(1'b1, 1'b1);
    rst = 1'b0;
    gx = 0; gy = 0; frame_no = 0;
    prev_locked = 1'b0;
    rise_code = -1;
    err_seen = 0;
    coord_bad = 0;
  endtask

  initial begin
    // Reset held with hsync low: no false edge on release.
    rst = 1'b1;
    repeat (3) drive(1'b0, 1'b1);
    check_eq("rst_h_cnt", h_cnt, 0);
    check_eq("rst_v_cnt", v_cnt, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_frame_start", frame_start, 0);
    check_eq("rst_sync_err", sync_err, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    repeat (5) drive(1'b0, 1'b1);
    check_eq("low_after_rst_h_cnt", h_cnt, 5);
    repeat (2) drive(1'b1, 1'b1);
    check_eq("hsync_high_h_cnt", h_cnt, 7);
    drive(1'b0, 1'b1);
    check_eq("first_fall_h_cnt", h_cnt, HF);
    check_eq("first_fall_no_err", sync_err, 0);

    // Ideal stream: lock after the third vsync edge, then one full locked frame.
    do_reset();
    run(3 * FRAME);
    check_eq("lock_point", rise_code, 2 * 10000 + VF * 100);
    valid_cnt = 0; fs_cnt = 0;
    run(FRAME);
    check_eq("valid_cycles", valid_cnt, HA * VA);
    check_eq("frame_start_cnt", fs_cnt, 1);
    check_eq("ideal_coord_bad", coord_bad, 0);
    check_eq("ideal_err_seen", err_seen, 0);
    check_eq("ideal_err_cnt", err_cnt, 0);
    check_eq("ideal_locked", locked, 1);

    // One hsync three samples early while locked.
    f_frame = 4; f_line = 3; f_fall = HF - 3; f_rise = HF + HS;
    rise_code = -1;
    run(3 * HT + HF - 3);
    check_eq("early_pre_locked", locked, 1);
    step();
    check_eq("early_sync_err", sync_err, 1);
    check_eq("early_locked", locked, 0);
    check_eq("early_err_cnt", err_cnt, 1);
    step();
    check_eq("early_err_pulse_end", sync_err, 0);
    run(FRAME - (3 * HT + HF - 1) + 2 * FRAME);
    check_eq("relock_point", rise_code, 6 * 10000 + VF * 100);
    check_eq("relock_err_cnt", err_cnt, 1);
    check_eq("relock_err_seen", err_seen, 1);
    check_eq("relock_coord_bad", coord_bad, 0);
    f_frame = -1;

    // hsync stuck high after the line-2 edge of a locked frame.
    run(2 * HT + HF + 1);
    for (int k = 1; k <= 60; k++) begin
      if (k == HS) stuck_hi = 1'b1;
      step();
      if (k == HT + 8) begin
        check_eq("stuck_no_err_yet", sync_err, 0);
        check_eq("stuck_still_locked", locked, 1);
      end
      if (k == HT + 9) begin
        check_eq("stuck_sync_err", sync_err, 1);
        check_eq("stuck_locked", locked, 0);
        check_eq("stuck_err_cnt", err_cnt, 2);
      end
      if (k == 60) check_eq("stuck_h_free_run", h_cnt, (HF + 60) % HT);
    end
    check_eq("stuck_coord_bad", coord_bad, 0);
    stuck_hi = 1'b0;

    // hsync pulse one sample short while locked.
    do_reset();
    f_frame = 3; f_line = 3; f_fall = HF; f_rise = HF + HS - 1;
    run(3 * FRAME + 3 * HT + HF + HS - 1);
    check_eq("short_pre_locked", locked, 1);
    step();
`ifdef VGA_DECODE_WIDTH_CHECK_EN
    check_eq("short_sync_err", sync_err, 1);
    check_eq("short_locked", locked, 0);
    check_eq("short_err_cnt", err_cnt, 1);
`else
    check_eq("short_sync_err", sync_err, 0);
    check_eq("short_locked", locked, 1);
    check_eq("short_err_cnt", err_cnt, 0);
`endif
    run(FRAME - (3 * HT + HF + HS) + FRAME);
`ifdef VGA_DECODE_WIDTH_CHECK_EN
    check_eq("short_after_locked", locked, 0);
    check_eq("short_after_err_cnt", err_cnt, 1);
`else
    check_eq("short_after_locked", locked, 1);
    check_eq("short_after_err_cnt", err_cnt, 0);
`endif
    f_frame = -1;

    // vsync falling on a line wrap far from the expected line.
    do_reset();
    run(5 * HT);
    check_eq("coinc_pre_h_cnt", h_cnt, HT - 1);
    check_eq("coinc_pre_v_cnt", v_cnt, 4);
    drive(1'b1, 1'b0);
    check_eq("coinc_v_cnt", v_cnt, VF);
    check_eq("coinc_h_cnt", h_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator.
- Takes a 640x480@60 hsync/vsync pair sampled on the 25 MHz pixel clock and rebuilds the pixel coordinates, the valid window and a lock indication from the sync edges alone.
- Used inside the game top as an on-chip monitor of the display timing, and as a bench-side checker for the display path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width in lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good vsync edges needed to declare lock (1..15)

Ports:
- clk  in  1  pixel clock (25 MHz); one sample per cycle
- rst  in  1  synchronous, active-high reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- h_cnt  out  10  recovered x of the sample taken in the previous cycle
- v_cnt  out  10  recovered y
- valid  out  1  locked && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
- locked  out  1  high in LOCKED state
- frame_start  out  1  one-cycle pulse when locked and (h_cnt,v_cnt) becomes (0,0)
- sync_err  out  1  one-cycle pulse on any timing violation
- err_cnt  out  8  saturating count of sync_err pulses

Behaviour:
- Reset values:
  - h_cnt=0, v_cnt=0, valid=0, locked=0, frame_start=0, sync_err=0, err_cnt=0.
  - State is SEARCH; hsync_q=0, vsync_q=0.
  - Because the delayed copies reset to 0, a sync held low through reset produces no false edge.
- Edge detect: fall_h = hsync_q & ~hsync; fall_v = vsync_q & ~vsync. The delayed copies update every cycle.
- The sample where hsync first reads low is pixel H_ACTIVE+H_FP (656). All outputs are registered, so latency is 1 cycle from sample to coordinate.
- h_cnt:
  - On fall_h: h_cnt<=656.
  - Otherwise: h_cnt<=h_cnt+1, wrapping from H_TOTAL-1 to 0.
- v_cnt:
  - Increments when h_cnt wraps, wrapping from V_TOTAL-1 to 0.
  - On fall_v: v_cnt<=V_ACTIVE+V_FP (490).
  - If fall_v and an h wrap coincide, fall_v wins.
- State machine:
  - SEARCH:
    - Counters free-run.
    - On the first fall_h, go to HLOCK. Good-frame count=0.
  - HLOCK:
    - Each fall_h requires h_cnt==655 (the previous sample index). On mismatch: sync_err, then SEARCH.
    - Each fall_v requires v_cnt==489, except the first fall_v after entering HLOCK, which only aligns v_cnt. On a pass, good-frame count+1; on a mismatch, sync_err and count=0, staying in HLOCK.
    - When the count reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED:
    - Same checks as HLOCK.
    - Any mismatch: sync_err, locked drops the next cycle, state returns to SEARCH.
- Missing hsync: if more than H_TOTAL+8 cycles pass since the last fall_h while in HLOCK or LOCKED, raise sync_err and go to SEARCH.
- Missing vsync: if more than V_TOTAL+2 lines pass since the last fall_v while in LOCKED, raise sync_err and go to SEARCH.
- err_cnt: increments on each sync_err and saturates at 255. Only rst clears it.
- frame_start and valid are gated by locked.
- rst mid-frame returns everything to the reset values; relock then needs LOCK_FRAMES+1 vsync edges again.

Optional Feature:
- Macro: VGA_DECODE_WIDTH_CHECK_EN.
- When defined:
  - A counter measures each hsync low pulse in cycles. On the rising edge, the width must be exactly H_SYNC.
  - The vsync low pulse is measured in line wraps and must equal V_SYNC.
  - A violation in HLOCK or LOCKED behaves exactly as an edge mismatch.
- When undefined: pulse widths are ignored and the counters are not built.

Test Plan:
- Ideal 640x480 stream, 4 frames after rst -> locked rises after the third fall_v; valid high for exactly 640x480 cycles per frame; frame_start once per 420000 cycles; err_cnt=0.
- Locked stream with one hsync moved 3 cycles early -> sync_err pulse; locked low the next cycle; err_cnt=1; relock after 3 further good vsync edges.
- hsync stuck high for 900 cycles while locked -> sync_err at cycle 809 after the last fall_h; state SEARCH; h_cnt keeps free-running.
- rst held with hsync=0, then released -> no edge until hsync rises and falls; first fall_h loads h_cnt=656 on the next cycle.
- fall_v coinciding with an h wrap -> v_cnt=490, not 0 or old+1.
- With VGA_DECODE_WIDTH_CHECK_EN, a 95-cycle hsync pulse while locked -> sync_err; locked drops. Without the macro, the same stimulus -> no error and lock held.
